// File: rtl/led_pwm_pio.sv
// Avalon-MM LED PWM controller with synchronised switch inputs, edge capture and interrupt.
// Define LED_PWM_PIO_PRESCALE_EN to include the 8-bit PWM prescaler (CTRL[15:8]).
module led_pwm_pio #(
    parameter int NUM_CH   = 8,
    parameter int PWM_BITS = 8,
    parameter int IN_W     = 4
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [3:0]          avs_address,
    input  logic                avs_write,
    input  logic                avs_read,
    input  logic [31:0]         avs_writedata,
    output logic [31:0]         avs_readdata,
    input  logic [IN_W-1:0]     sw_in,
    output logic [NUM_CH-1:0]   led_out,
    output logic                irq
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    logic                r_en;
`ifdef LED_PWM_PIO_PRESCALE_EN
    logic [7:0]          r_prescale;
    logic [7:0]          r_pre_cnt;
`endif
    logic [IN_W-1:0]     r_sync1;
    logic [IN_W-1:0]     r_sync2;
    logic [IN_W-1:0]     r_sync3;
    logic [IN_W-1:0]     r_edge;
    logic [IN_W-1:0]     r_irq_mask;
    logic [1:0]          r_arm_cnt;
    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_duty_sh  [NUM_CH];
    logic [PWM_BITS-1:0] r_duty_act [NUM_CH];
    logic [NUM_CH-1:0]   r_led;
    logic                r_irq;
    logic [31:0]         r_rdata;

    logic                w_wr_ctrl;
    logic                w_wr_mask;
    logic                w_tick;
    logic                w_wrap;
    logic [IN_W-1:0]     w_rise;
    logic [IN_W-1:0]     w_edge_clr;
    logic [31:0]         w_rdata;
    logic                w_unused_wdata;

    assign w_wr_ctrl      = avs_write && (avs_address == 4'd0);
    assign w_wr_mask      = avs_write && (avs_address == 4'd3);
    assign w_edge_clr     = (avs_write && (avs_address == 4'd2)) ? avs_writedata[IN_W-1:0] : '0;
    assign w_unused_wdata = ^avs_writedata;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_en       <= 1'b0;
            r_irq_mask <= '0;
`ifdef LED_PWM_PIO_PRESCALE_EN
            r_prescale <= '0;
`endif
        end else begin
            if (w_wr_ctrl) begin
                r_en <= avs_writedata[0];
`ifdef LED_PWM_PIO_PRESCALE_EN
                r_prescale <= avs_writedata[15:8];
`endif
            end
            if (w_wr_mask) begin
                r_irq_mask <= avs_writedata[IN_W-1:0];
            end
        end
    end

`ifdef LED_PWM_PIO_PRESCALE_EN
    // ">=" keeps the prescaler from running past a PRESCALE value lowered mid-count
    assign w_tick = r_en && (r_pre_cnt >= r_prescale);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_pre_cnt <= '0;
        end else if (!r_en || w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 8'd1;
        end
    end
`else
    assign w_tick = r_en;
`endif

    assign w_wrap = w_tick && (r_cnt == CNT_MAX);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cnt <= '0;
            r_led <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_duty_sh[i]  <= '0;
                r_duty_act[i] <= '0;
            end
        end else begin
            if (!r_en) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + 1'b1;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (avs_write && (avs_address == 4'(8 + i))) begin
                    r_duty_sh[i] <= avs_writedata[PWM_BITS-1:0];
                end
                if (w_wrap) begin
                    r_duty_act[i] <= r_duty_sh[i];
                end
                r_led[i] <= r_en && (r_cnt < r_duty_act[i]);
            end
        end
    end

    // Edges stay masked until the synchroniser has filled with post-reset input values
    assign w_rise = (r_arm_cnt == 2'd0) ? (r_sync2 & ~r_sync3) : '0;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync3   <= '0;
            r_arm_cnt <= 2'd3;
            r_edge    <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_sync1 <= sw_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (r_arm_cnt != 2'd0) begin
                r_arm_cnt <= r_arm_cnt - 2'd1;
            end
            r_edge <= (r_edge & ~w_edge_clr) | w_rise;
            r_irq  <= |(r_edge & r_irq_mask);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            4'd0: begin
                w_rdata[0] = r_en;
`ifdef LED_PWM_PIO_PRESCALE_EN
                w_rdata[15:8] = r_prescale;
`endif
            end
            4'd1:    w_rdata[IN_W-1:0] = r_sync2;
            4'd2:    w_rdata[IN_W-1:0] = r_edge;
            4'd3:    w_rdata[IN_W-1:0] = r_irq_mask;
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (avs_address == 4'(8 + i)) begin
                        w_rdata[PWM_BITS-1:0] = r_duty_sh[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= avs_read ? w_rdata : '0;
        end
    end

    assign avs_readdata = r_rdata;
    assign led_out      = r_led;
    assign irq          = r_irq;

endmodule

// File: tb/tb_led_pwm_pio.sv
// Self-checking bench for led_pwm_pio: register map, PWM duty/shadowing, prescaler, edges/irq, reset.
// Expectations follow LED_PWM_PIO_PRESCALE_EN when it is defined for the build.
module tb_led_pwm_pio;
    localparam int NUM_CH   = 8;
    localparam int PWM_BITS = 8;
    localparam int IN_W     = 4;

    logic              clk_clk       = 1'b0;
    logic              reset_reset_n = 1'b0;
    logic [3:0]        avs_address   = '0;
    logic              avs_write     = 1'b0;
    logic              avs_read      = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
    logic [IN_W-1:0]   sw_in         = '0;
    logic [NUM_CH-1:0] led_out;
    logic              irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [IN_W-1:0] m_edge;
    logic [IN_W-1:0] m_in;
    logic [IN_W-1:0] m_mask;

    led_pwm_pio #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .IN_W(IN_W)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .avs_address(avs_address), .avs_write(avs_write), .avs_read(avs_read),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .sw_in(sw_in), .led_out(led_out), .irq(irq)
    );

    always #5 clk_clk = ~clk_clk;

`ifdef LED_PWM_PIO_PRESCALE_EN
    localparam bit HAS_PRE = 1'b1;
`else
    localparam bit HAS_PRE = 1'b0;
`endif

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk_clk);
        avs_write = 1'b1; avs_address = a; avs_writedata = d;
        @(negedge clk_clk);
        avs_write = 1'b0; avs_writedata = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk_clk);
        avs_read = 1'b1; avs_address = a;
        @(negedge clk_clk);
        d = avs_readdata;
        avs_read = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(negedge clk_clk);
        n_checks++; if (led_out !== '0) begin n_errors++; $display("FAIL reset_led: got %0h expected 0", led_out); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        n_checks++; if (avs_readdata !== '0) begin n_errors++; $display("FAIL reset_rdata: got %0h expected 0", avs_readdata); end
        reset_reset_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), d);
            n_checks++; if (d !== '0) begin n_errors++; $display("FAIL reset_reg%0d: got %0h expected 0", a, d); end
        end
    endtask

    task automatic test_readback();
        logic [31:0] d, v;
        bus_write(4'd0, 32'h0000_0301);
        bus_read(4'd0, d);
        v = HAS_PRE ? 32'h0000_0301 : 32'h0000_0001;
        n_checks++; if (d !== v) begin n_errors++; $display("FAIL ctrl_readback: got %0h expected %0h", d, v); end
        bus_write(4'd5, 32'hFFFF_FFFF);
        bus_read(4'd5, d);
        n_checks++; if (d !== '0) begin n_errors++; $display("FAIL addr5_read: got %0h expected 0", d); end
        bus_write(4'd11, 32'h0000_1234);
        bus_read(4'd11, d);
        n_checks++; if (d !== 32'h34) begin n_errors++; $display("FAIL duty_trunc: got %0h expected 34", d); end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            v = $urandom;
            bus_write(4'(8 + ch), v);
            bus_read(4'(8 + ch), d);
            n_checks++; if (d !== (v & 32'hFF)) begin n_errors++; $display("FAIL duty_readback%0d: got %0h expected %0h", ch, d, v & 32'hFF); end
        end
        bus_write(4'd3, 32'hFFFF_FFF5);
        bus_read(4'd3, d);
        n_checks++; if (d !== 32'h5) begin n_errors++; $display("FAIL mask_readback: got %0h expected 5", d); end
        bus_write(4'd3, 32'h0);
    endtask

    task automatic test_enable_off();
        bus_write(4'd8, 32'd255);
        bus_write(4'd0, 32'h1);
        repeat (600) @(negedge clk_clk);
        bus_write(4'd0, 32'h0);
        @(negedge clk_clk);
        n_checks++; if (led_out !== '0) begin n_errors++; $display("FAIL en_clear_led: got %0h expected 0", led_out); end
        repeat (300) @(negedge clk_clk);
        n_checks++; if (led_out !== '0) begin n_errors++; $display("FAIL en_off_hold: got %0h expected 0", led_out); end
    endtask

    task automatic test_pwm_random();
        int duty [NUM_CH];
        int hi   [NUM_CH];
        int p, mult, period;
        for (int t = 0; t < 2; t++) begin
            for (int ch = 0; ch < NUM_CH; ch++) duty[ch] = $urandom_range(0, 255);
            if (t == 0) begin duty[0] = 64; duty[2] = 0; duty[7] = 255; end
            p      = $urandom_range(0, 2);
            mult   = HAS_PRE ? p + 1 : 1;
            period = 256 * mult;
            for (int ch = 0; ch < NUM_CH; ch++) bus_write(4'(8 + ch), 32'(duty[ch]));
            bus_write(4'd0, 32'(1 | (p << 8)));
            repeat (2 * period + 8) @(negedge clk_clk);
            for (int ch = 0; ch < NUM_CH; ch++) hi[ch] = 0;
            repeat (period) begin
                @(negedge clk_clk);
                for (int ch = 0; ch < NUM_CH; ch++) if (led_out[ch]) hi[ch]++;
            end
            for (int ch = 0; ch < NUM_CH; ch++) begin
                n_checks++;
                if (hi[ch] != duty[ch] * mult) begin
                    n_errors++;
                    $display("FAIL pwm_t%0d_ch%0d: got %0d high cycles expected %0d", t, ch, hi[ch], duty[ch] * mult);
                end
            end
        end
    endtask

    task automatic test_prescale();
        int hi, mult, exp_hi;
        bus_write(4'd9, 32'd2);
        bus_write(4'd0, 32'h0301);
        mult   = HAS_PRE ? 4 : 1;
        exp_hi = 2 * mult * (1024 / (256 * mult));
        repeat (2 * 1024 + 8) @(negedge clk_clk);
        hi = 0;
        repeat (1024) begin
            @(negedge clk_clk);
            if (led_out[1]) hi++;
        end
        n_checks++; if (hi != exp_hi) begin n_errors++; $display("FAIL prescale_ch1: got %0d high cycles expected %0d", hi, exp_hi); end
    endtask

    task automatic test_shadow();
        logic prev;
        int   guard, low, high;
        bit   found;
        bus_write(4'd8, 32'd64);
        bus_write(4'd0, 32'h1);
        repeat (600) @(negedge clk_clk);
        found = 0; guard = 0; prev = led_out[0];
        while (!found && guard < 600) begin
            @(negedge clk_clk);
            if (prev && !led_out[0]) found = 1;
            prev = led_out[0];
            guard++;
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL shadow_fall_timeout: got no falling edge expected one"); end
        low = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_clk);
            if (k == 36) begin avs_write = 1'b1; avs_address = 4'd8; avs_writedata = 32'd200; end
            else if (k == 37) begin avs_write = 1'b0; avs_writedata = '0; end
            if (!led_out[0]) low++;
        end
        guard = 0;
        while (guard < 400) begin
            @(negedge clk_clk);
            if (led_out[0]) break;
            low++; guard++;
        end
        n_checks++; if (low != 192) begin n_errors++; $display("FAIL shadow_old_duty_low: got %0d expected 192", low); end
        high = 1; guard = 0;
        while (guard < 400) begin
            @(negedge clk_clk);
            if (!led_out[0]) break;
            high++; guard++;
        end
        n_checks++; if (high != 200) begin n_errors++; $display("FAIL shadow_new_duty_high: got %0d expected 200", high); end
    endtask

    task automatic test_edges();
        logic [31:0] d;
        logic [IN_W-1:0] nv, c;
        int lat;
        bus_write(4'd0, 32'h0);
        bus_write(4'd3, 32'h4);
        @(negedge clk_clk);
        sw_in[2] = 1'b1;
        lat = 0;
        while (lat < 8) begin
            @(negedge clk_clk);
            lat++;
            if (irq) break;
        end
        n_checks++; if (lat != 4 || irq !== 1'b1) begin n_errors++; $display("FAIL edge_irq_latency: got %0d cycles irq=%0b expected 4 cycles irq=1", lat, irq); end
        bus_read(4'd2, d);
        n_checks++; if (d !== 32'h4) begin n_errors++; $display("FAIL edge_read: got %0h expected 4", d); end
        bus_write(4'd2, 32'h4);
        @(negedge clk_clk);
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL edge_clear_irq: got %0b expected 0", irq); end
        @(negedge clk_clk);
        sw_in[0] = 1'b1;
        @(negedge clk_clk);
        @(negedge clk_clk);
        avs_write = 1'b1; avs_address = 4'd2; avs_writedata = 32'h1;
        @(negedge clk_clk);
        avs_write = 1'b0; avs_writedata = '0;
        bus_read(4'd2, d);
        n_checks++; if (d !== 32'h1) begin n_errors++; $display("FAIL edge_set_beats_clear: got %0h expected 1", d); end
        bus_write(4'd2, 32'h1);
        bus_read(4'd2, d);
        n_checks++; if (d !== 32'h0) begin n_errors++; $display("FAIL edge_clear_bit0: got %0h expected 0", d); end

        m_edge = '0; m_in = sw_in; m_mask = IN_W'($urandom);
        bus_write(4'd3, 32'(m_mask));
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 8; s++) begin
                nv = IN_W'($urandom);
                @(negedge clk_clk);
                sw_in  = nv;
                m_edge = m_edge | (nv & ~m_in);
                m_in   = nv;
                repeat (4) @(negedge clk_clk);
            end
            bus_read(4'd1, d);
            n_checks++; if (d !== 32'(m_in)) begin n_errors++; $display("FAIL rand_in_r%0d: got %0h expected %0h", r, d, m_in); end
            bus_read(4'd2, d);
            n_checks++; if (d !== 32'(m_edge)) begin n_errors++; $display("FAIL rand_edge_r%0d: got %0h expected %0h", r, d, m_edge); end
            n_checks++; if (irq !== |(m_edge & m_mask)) begin n_errors++; $display("FAIL rand_irq_r%0d: got %0b expected %0b", r, irq, |(m_edge & m_mask)); end
            c = IN_W'($urandom);
            bus_write(4'd2, 32'(c));
            m_edge = m_edge & ~c;
            @(negedge clk_clk);
            bus_read(4'd2, d);
            n_checks++; if (d !== 32'(m_edge)) begin n_errors++; $display("FAIL rand_clear_r%0d: got %0h expected %0h", r, d, m_edge); end
            n_checks++; if (irq !== |(m_edge & m_mask)) begin n_errors++; $display("FAIL rand_clear_irq_r%0d: got %0b expected %0b", r, irq, |(m_edge & m_mask)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int guard;
        sw_in = '1;
        for (int ch = 0; ch < NUM_CH; ch++) bus_write(4'(8 + ch), 32'd255);
        bus_write(4'd0, 32'h1);
        repeat (300) @(negedge clk_clk);
        guard = 0;
        while (led_out !== '1 && guard < 700) begin
            @(negedge clk_clk);
            guard++;
        end
        n_checks++; if (led_out !== '1) begin n_errors++; $display("FAIL mid_reset_leds_on: got %0h expected ff", led_out); end
        avs_read = 1'b1; avs_address = 4'd0;
        #2;
        reset_reset_n = 1'b0;
        avs_read = 1'b0;
        #1;
        n_checks++; if (led_out !== '0) begin n_errors++; $display("FAIL mid_reset_led: got %0h expected 0", led_out); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL mid_reset_irq: got %0b expected 0", irq); end
        n_checks++; if (avs_readdata !== '0) begin n_errors++; $display("FAIL mid_reset_rdata: got %0h expected 0", avs_readdata); end
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (6) @(negedge clk_clk);
        n_checks++; if (led_out !== '0 || irq !== 1'b0) begin n_errors++; $display("FAIL post_reset_outputs: got led=%0h irq=%0b expected 0 0", led_out, irq); end
        for (int a = 0; a < 16; a++) begin
            bus_read(4'(a), d);
            if (a == 1) begin
                n_checks++; if (d !== 32'hF) begin n_errors++; $display("FAIL post_reset_in: got %0h expected f", d); end
            end else begin
                n_checks++; if (d !== '0) begin n_errors++; $display("FAIL post_reset_reg%0d: got %0h expected 0", a, d); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_readback();
        test_enable_off();
        test_pwm_random();
        test_prescale();
        test_shadow();
        test_edges();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
